// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: owns the PC, fetches over a req/ack handshake and
// issues words over valid/ready. Define IFU_ILLEGAL_TRAP_EN to trap undecoded opcodes.
module instr_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [PC_W-1:0] instr_pc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] kill_pc;
  logic            kill;
  logic [15:0]     instr_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            take_ack;
  logic            trap;
  logic            redirect;
  logic [PC_W-1:0] target_aligned;

  assign redirect       = branch_taken && (state != HALT);
  assign target_aligned = {branch_target[PC_W-1:1], 1'b0};
  // An ack is only consumed when it belongs to a live request and no redirect lands with it.
  assign take_ack       = (state == FETCH) && imem_ack && !kill && !branch_taken;

`ifdef IFU_ILLEGAL_TRAP_EN
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
  endfunction

  logic illegal_q;

  assign trap = !is_legal(imem_rdata[15:12]);

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (take_ack && trap)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; no latch can be inferred.
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (take_ack) state_nxt = trap ? HALT : HOLD;
      HOLD:  if (branch_taken || instr_ready) state_nxt = FETCH;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
    // A killed request keeps presenting its original address until its ack returns.
    imem_addr   = kill ? kill_pc : pc;
    instr       = instr_q;
    opcode      = instr_q[15:12];
    instr_pc    = instr_pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      kill       <= 1'b0;
      kill_pc    <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      if (redirect)
        pc <= target_aligned;
      else if (take_ack)
        pc <= pc + PC_W'(2);

      if (state == FETCH) begin
        if (imem_ack) begin
          kill <= 1'b0;
        end else if (branch_taken) begin
          kill <= 1'b1;
          if (!kill)
            kill_pc <= pc;
        end
      end

      if (take_ack) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with programmable wait states and
// a scoreboard of expected issued instructions; works with or without IFU_ILLEGAL_TRAP_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] instr_pc;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        illegal;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
  } issue_t;
  issue_t exp_q[$];

  logic [15:0] mem [0:32767];
  int          delay;
  int          wait_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .illegal       (illegal)
  );

  // Memory answers `delay` cycles after a request starts; delay 0 acks in the request cycle.
  assign imem_ack   = imem_req && (wait_cnt >= delay);
  assign imem_rdata = mem[imem_addr[15:1]];

  always @(posedge clk) begin
    if (!imem_req || imem_ack)
      wait_cnt <= 0;
    else
      wait_cnt <= wait_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_issue(input logic [15:0] pc, input logic [15:0] word);
    issue_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Handshake must complete in the current cycle; compare against the oldest expectation.
  task automatic expect_issue(input string tag);
    issue_t e;
    check({tag, "_handshake"}, {30'b0, instr_valid, instr_ready}, 32'h3);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_instr"},  instr,    e.word);
      check({tag, "_opcode"}, opcode,   e.word[15:12]);
      check({tag, "_pc"},     instr_pc, e.pc);
    end
  endtask

  task automatic load(input logic [15:0] addr, input logic [15:0] word);
    mem[addr[15:1]] = word;
  endtask

  initial begin
    rst           = 1'b1;
    instr_ready   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    delay         = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    load(16'h0000, 16'h1234);
    load(16'h0002, 16'h9ABC);
    load(16'h0004, 16'h2222);
    load(16'h0006, 16'hA006);
    load(16'h0008, 16'hB008);
    load(16'h0040, 16'hC040);
    load(16'h0042, 16'hD042);
    load(16'h0100, 16'hF100);
    load(16'h0102, 16'h0102);
    load(16'hFFFE, 16'h1FFE);
    load(16'h0200, 16'h3000);

    repeat (3) cyc();
    check("rst_req",      imem_req,    0);
    check("rst_addr",     imem_addr,   16'h0000);
    check("rst_valid",    instr_valid, 0);
    check("rst_instr",    instr,       0);
    check("rst_opcode",   opcode,      0);
    check("rst_instr_pc", instr_pc,    0);
    check("rst_illegal",  illegal,     0);

    // Zero-wait streaming: request, then valid the next cycle
    rst = 1'b0;
    cyc();
    check("req0", imem_req, 1);
    check("addr0", imem_addr, 16'h0000);
    push_issue(16'h0000, 16'h1234);
    cyc();
    expect_issue("first");
    check("req_in_hold", imem_req, 0);
    cyc();
    check("req1", imem_req, 1);
    check("addr1", imem_addr, 16'h0002);
    push_issue(16'h0002, 16'h9ABC);
    cyc();
    expect_issue("second");

    // Backpressure: three cycles of ready low in HOLD
    cyc();
    check("addr2", imem_addr, 16'h0004);
    push_issue(16'h0004, 16'h2222);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_valid", instr_valid, 1);
      check("bp_instr", instr, 16'h2222);
      check("bp_pc",    instr_pc, 16'h0004);
      check("bp_req",   imem_req, 0);
    end
    instr_ready = 1'b1;
    delay = 3;
    expect_issue("bp_release");

    // Three wait states: address held for four cycles, one instruction issued
    cyc();
    push_issue(16'h0006, 16'hA006);
    for (int k = 0; k < 4; k++) begin
      check("wait_req",   imem_req, 1);
      check("wait_addr",  imem_addr, 16'h0006);
      check("wait_valid", instr_valid, 0);
      if (k < 3) cyc();
    end
    delay = 0;
    cyc();
    expect_issue("delayed");
    cyc();
    check("after_delay_valid", instr_valid, 0);
    check("after_delay_addr",  imem_addr, 16'h0008);

    // Branch in HOLD with ready high discards the held word; target LSB dropped
    cyc();
    check("hold_br_valid", instr_valid, 1);
    check("hold_br_instr", instr, 16'hB008);
    branch_taken  = 1'b1;
    branch_target = 16'h0041;
    cyc();
    branch_taken = 1'b0;
    check("br_discard_valid", instr_valid, 0);
    check("br_req",  imem_req, 1);
    check("br_addr", imem_addr, 16'h0040);
    push_issue(16'h0040, 16'hC040);
    cyc();
    expect_issue("br_target");
    cyc();
    check("seq_addr_42", imem_addr, 16'h0042);
    cyc();
    check("hold_d042", instr, 16'hD042);
    branch_taken  = 1'b1;
    branch_target = 16'h0004;
    delay = 2;

    // Branch during a pending fetch: request held, returned word discarded
    cyc();
    check("pend_req",  imem_req, 1);
    check("pend_addr", imem_addr, 16'h0004);
    branch_target = 16'h0100;
    cyc();
    branch_taken = 1'b0;
    check("kill_req",   imem_req, 1);
    check("kill_addr",  imem_addr, 16'h0004);
    check("kill_valid", instr_valid, 0);
    cyc();
    check("kill_ack_addr",  imem_addr, 16'h0004);
    check("kill_ack_valid", instr_valid, 0);
    delay = 0;
    cyc();
    check("after_kill_valid", instr_valid, 0);
    check("after_kill_req",   imem_req, 1);
    check("after_kill_addr",  imem_addr, 16'h0100);
    push_issue(16'h0100, 16'hF100);
    cyc();
    expect_issue("kill_target");

    // Branch coincident with an ack: that data is dropped, fetch restarts at target
    cyc();
    check("coinc_addr", imem_addr, 16'h0102);
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    cyc();
    branch_taken = 1'b0;
    check("coinc_valid", instr_valid, 0);
    check("coinc_new_addr", imem_addr, 16'hFFFE);
    push_issue(16'hFFFE, 16'h1FFE);
    cyc();
    expect_issue("top_of_mem");
    cyc();
    check("wrap_addr", imem_addr, 16'h0000);
    push_issue(16'h0000, 16'h1234);
    cyc();
    expect_issue("wrapped");

    // Opcode 0x3: trapped or issued depending on build
    cyc();
    check("pre_illegal_addr", imem_addr, 16'h0002);
    branch_taken  = 1'b1;
    branch_target = 16'h0200;
    cyc();
    branch_taken = 1'b0;
    check("illegal_fetch_addr", imem_addr, 16'h0200);
`ifdef IFU_ILLEGAL_TRAP_EN
    cyc();
    check("trap_illegal",  illegal, 1);
    check("trap_valid",    instr_valid, 0);
    check("trap_req",      imem_req, 0);
    check("trap_instr_pc", instr_pc, 16'h0200);
    branch_taken  = 1'b1;
    branch_target = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      branch_taken = 1'b0;
      check("halt_req",     imem_req, 0);
      check("halt_valid",   instr_valid, 0);
      check("halt_illegal", illegal, 1);
    end
`else
    push_issue(16'h0200, 16'h3000);
    cyc();
    expect_issue("op3_issue");
    check("no_trap_illegal", illegal, 0);
`endif

    // Reset mid-fetch abandons the request
    rst = 1'b1;
    cyc();
    check("rst2_req",     imem_req, 0);
    check("rst2_illegal", illegal, 0);
    check("rst2_valid",   instr_valid, 0);
    delay = 3;
    rst = 1'b0;
    cyc();
    check("midfetch_req",  imem_req, 1);
    check("midfetch_addr", imem_addr, 16'h0000);
    rst = 1'b1;
    cyc();
    check("abandon_req", imem_req, 0);
    delay = 0;
    rst = 1'b0;
    cyc();
    check("restart_req",  imem_req, 1);
    check("restart_addr", imem_addr, 16'h0000);
    push_issue(16'h0000, 16'h1234);
    cyc();
    expect_issue("restart");

    check("sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
